// File: rtl/flag_unit.sv
// ============================================================================
// Module   : flag_unit
// Purpose  : Condition-flag register {Z,V,N}, branch resolution with
//            same-cycle EX bypass, and a saturating ADD/SUB overflow counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flag_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [3:0]  ex_op,
  input  logic [15:0] ex_out,
  input  logic        ex_ovfl,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_eval,
  input  logic [2:0]  br_ccc,
  output logic [2:0]  flags,
  output logic        br_valid,
  output logic        br_taken,
  output logic [7:0]  ovfl_cnt
);

  localparam logic [3:0] c_OP_ADD = 4'b0000;
  localparam logic [3:0] c_OP_SUB = 4'b0001;
  localparam logic [3:0] c_OP_XOR = 4'b0011;
  localparam logic [3:0] c_OP_SLL = 4'b0100;
  localparam logic [3:0] c_OP_SRA = 4'b0101;
  localparam logic [3:0] c_OP_ROR = 4'b0110;

  localparam logic [7:0] c_CNT_MAX = 8'hFF;

  logic w_commit;
  logic w_addsub;
  logic w_zonly;
  logic w_z_res;
  logic w_eff_z;
  logic w_eff_v;
  logic w_eff_n;
  logic w_cond;
  logic w_br_accept;

  assign w_commit    = ex_valid & ~stall & ~flush;
  assign w_br_accept = br_eval & ~stall & ~flush;
  assign w_addsub    = (ex_op == c_OP_ADD) || (ex_op == c_OP_SUB);
  assign w_zonly     = (ex_op == c_OP_XOR) || (ex_op == c_OP_SLL) ||
                       (ex_op == c_OP_SRA) || (ex_op == c_OP_ROR);
  assign w_z_res     = (ex_out == 16'h0000);

  // Branches see the flags this cycle's commit would write, not the stale ones.
  assign w_eff_z = (w_commit && (w_addsub || w_zonly)) ? w_z_res : flags[2];
  assign w_eff_v = (w_commit && w_addsub) ? ex_ovfl   : flags[1];
  assign w_eff_n = (w_commit && w_addsub) ? ex_out[15] : flags[0];

  always_comb begin
    w_cond = 1'b0;
    case (br_ccc)
      3'b000:  w_cond = ~w_eff_z;
      3'b001:  w_cond = w_eff_z;
      3'b010:  w_cond = ~w_eff_z & ~w_eff_n;
      3'b011:  w_cond = w_eff_n;
      3'b100:  w_cond = w_eff_z | ~w_eff_n;
      3'b101:  w_cond = w_eff_z | w_eff_n;
      3'b110:  w_cond = w_eff_v;
      default: w_cond = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags    <= 3'b000;
      br_valid <= 1'b0;
      br_taken <= 1'b0;
      ovfl_cnt <= 8'h00;
    end else begin
      if (w_commit && w_addsub) begin
        flags <= {w_z_res, ex_ovfl, ex_out[15]};
      end else if (w_commit && w_zonly) begin
        flags[2] <= w_z_res;
      end

      br_valid <= w_br_accept;
      br_taken <= w_br_accept & w_cond;

      if (w_commit && w_addsub && ex_ovfl && (ovfl_cnt != c_CNT_MAX)) begin
        ovfl_cnt <= ovfl_cnt + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flag_unit.sv
// ============================================================================
// Module   : tb_flag_unit
// Purpose  : Directed self-checking bench for flag_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flag_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [15:0] ex_out;
  logic        ex_ovfl;
  logic        stall;
  logic        flush;
  logic        br_eval;
  logic [2:0]  br_ccc;
  logic [2:0]  flags;
  logic        br_valid;
  logic        br_taken;
  logic [7:0]  ovfl_cnt;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [3:0] c_ADD    = 4'b0000;
  localparam logic [3:0] c_SUB    = 4'b0001;
  localparam logic [3:0] c_RED    = 4'b0010;
  localparam logic [3:0] c_XOR    = 4'b0011;
  localparam logic [3:0] c_SLL    = 4'b0100;
  localparam logic [3:0] c_PADDSB = 4'b0111;
  localparam logic [3:0] c_MEM    = 4'b1000;
  localparam logic [3:0] c_CTRL   = 4'b1100;

  flag_unit u_dut (
    .clk      (clk),
    .rst      (rst),
    .ex_valid (ex_valid),
    .ex_op    (ex_op),
    .ex_out   (ex_out),
    .ex_ovfl  (ex_ovfl),
    .stall    (stall),
    .flush    (flush),
    .br_eval  (br_eval),
    .br_ccc   (br_ccc),
    .flags    (flags),
    .br_valid (br_valid),
    .br_taken (br_taken),
    .ovfl_cnt (ovfl_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_op = 4'h0; ex_out = 16'h0; ex_ovfl = 1'b0;
    stall = 1'b0; flush = 1'b0; br_eval = 1'b0; br_ccc = 3'b000;
  endtask

  task automatic ex(input logic [3:0] op, input logic [15:0] res, input logic ov);
    ex_valid = 1'b1; ex_op = op; ex_out = res; ex_ovfl = ov;
  endtask

  task automatic br(input logic [2:0] ccc);
    br_eval = 1'b1; br_ccc = ccc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected branch decision per ccc with flags {Z,V,N} = 000.
  logic [7:0] r_exp_taken_000 = 8'b1001_0101;

  initial begin
    idle();
    rst = 1'b1;
    repeat (3) step();
    check("reset_flags", {13'd0, flags}, 16'h0000);
    check("reset_bv",    {15'd0, br_valid}, 16'h0000);
    check("reset_bt",    {15'd0, br_taken}, 16'h0000);
    check("reset_cnt",   {8'd0, ovfl_cnt}, 16'h0000);
    rst = 1'b0;

    for (int c = 0; c < 8; c++) begin
      idle(); br(3'(c)); step();
      check($sformatf("ccc%0d_bv", c), {15'd0, br_valid}, 16'h0001);
      check($sformatf("ccc%0d_bt", c), {15'd0, br_taken}, {15'd0, r_exp_taken_000[c]});
    end
    idle(); step();
    check("bv_drop", {15'd0, br_valid}, 16'h0000);
    check("bt_drop", {15'd0, br_taken}, 16'h0000);

    // ADD zero result with overflow
    ex(c_ADD, 16'h0000, 1'b1); step(); idle();
    check("add_zero_flags", {13'd0, flags}, 16'h0006);
    check("add_zero_cnt",   {8'd0, ovfl_cnt}, 16'h0001);

    // SUB then XOR: XOR keeps V and N
    ex(c_SUB, 16'h8001, 1'b0); step(); idle();
    check("sub_flags", {13'd0, flags}, 16'h0001);
    ex(c_XOR, 16'h0000, 1'b1); step(); idle();
    check("xor_flags", {13'd0, flags}, 16'h0005);
    check("xor_cnt",   {8'd0, ovfl_cnt}, 16'h0001);

    // Clear flags, then LT bypass
    ex(c_ADD, 16'h0001, 1'b0); step(); idle();
    check("clear_flags", {13'd0, flags}, 16'h0000);
    ex(c_ADD, 16'hFFFF, 1'b0); br(3'b011); step(); idle();
    check("bypass_lt_bv", {15'd0, br_valid}, 16'h0001);
    check("bypass_lt_bt", {15'd0, br_taken}, 16'h0001);
    check("bypass_lt_flags", {13'd0, flags}, 16'h0001);

    // NE with bypass: back-to-back commit, branch sees the XOR's Z
    ex(c_XOR, 16'h0000, 1'b0); br(3'b000); step(); idle();
    check("bypass_ne_bv", {15'd0, br_valid}, 16'h0001);
    check("bypass_ne_bt", {15'd0, br_taken}, 16'h0000);
    check("b2b_flags",    {13'd0, flags}, 16'h0005);

    // Stall / flush on branch, then release, then stall clears br_valid
    br(3'b111); stall = 1'b1; step(); idle();
    check("stall_bv", {15'd0, br_valid}, 16'h0000);
    br(3'b111); flush = 1'b1; step(); idle();
    check("flush_bv", {15'd0, br_valid}, 16'h0000);
    br(3'b111); stall = 1'b1; flush = 1'b1; step(); idle();
    check("flush_stall_bv", {15'd0, br_valid}, 16'h0000);
    br(3'b111); step(); idle();
    check("release_bv", {15'd0, br_valid}, 16'h0001);
    check("release_bt", {15'd0, br_taken}, 16'h0001);
    br(3'b111); stall = 1'b1; step(); idle();
    check("stall_clear_bv", {15'd0, br_valid}, 16'h0000);
    check("stall_clear_bt", {15'd0, br_taken}, 16'h0000);

    // Stalled and flushed commits must not touch flags or the counter
    ex(c_ADD, 16'h8000, 1'b1); stall = 1'b1; step(); idle();
    check("stall_ex_flags", {13'd0, flags}, 16'h0005);
    check("stall_ex_cnt",   {8'd0, ovfl_cnt}, 16'h0001);
    ex(c_ADD, 16'h8000, 1'b1); flush = 1'b1; step(); idle();
    check("flush_ex_flags", {13'd0, flags}, 16'h0005);
    check("flush_ex_cnt",   {8'd0, ovfl_cnt}, 16'h0001);

    // OVFL condition on registered V=0
    br(3'b110); step(); idle();
    check("ovfl_cond_bt", {15'd0, br_taken}, 16'h0000);

    // Counter saturation
    for (int i = 0; i < 253; i++) begin
      ex(c_ADD, 16'h1234, 1'b1); step();
    end
    idle();
    check("cnt_fe", {8'd0, ovfl_cnt}, 16'h00FE);
    for (int i = 0; i < 47; i++) begin
      ex(c_ADD, 16'h1234, 1'b1); step();
    end
    idle();
    check("cnt_sat", {8'd0, ovfl_cnt}, 16'h00FF);
    check("sat_flags", {13'd0, flags}, 16'h0002);

    // Ops that leave flags alone; ex_ovfl ignored outside ADD/SUB
    ex(c_PADDSB, 16'h0000, 1'b1); step(); idle();
    check("paddsb_flags", {13'd0, flags}, 16'h0002);
    check("paddsb_cnt",   {8'd0, ovfl_cnt}, 16'h00FF);
    ex(c_RED, 16'h0000, 1'b1); step();
    ex(c_MEM, 16'h0000, 1'b1); step();
    ex(c_CTRL, 16'h0000, 1'b1); step(); idle();
    check("nop_ops_flags", {13'd0, flags}, 16'h0002);
    ex(c_SLL, 16'h0000, 1'b0); step(); idle();
    check("sll_flags", {13'd0, flags}, 16'h0006);

    // Build flags=111, then reset with a pending branch
    ex(c_ADD, 16'h8000, 1'b1); step();
    ex(c_XOR, 16'h0000, 1'b0); step(); idle();
    check("pre_rst_flags", {13'd0, flags}, 16'h0007);
    rst = 1'b1; br(3'b111); ex(c_ADD, 16'h8000, 1'b1);
    #2;
    check("rst_async_flags", {13'd0, flags}, 16'h0007);
    check("rst_async_cnt",   {8'd0, ovfl_cnt}, 16'h00FF);
    step();
    check("rst_flags", {13'd0, flags}, 16'h0000);
    check("rst_bv",    {15'd0, br_valid}, 16'h0000);
    check("rst_cnt",   {8'd0, ovfl_cnt}, 16'h0000);
    rst = 1'b0; idle(); step();
    check("post_rst_flags", {13'd0, flags}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  single system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX-stage ALU result is valid this cycle
- ex_op  in  4  opcode of EX instruction (ADD=0000, SUB=0001, RED=0010, XOR=0011, SLL=0100, SRA=0101, ROR=0110, PADDSB=0111, 10xx mem, 11xx ctrl)
- ex_out  in  16  ALU result
- ex_ovfl  in  1  ALU overflow
- stall  in  1  pipeline hold; blocks flag and branch state updates
- flush  in  1  squash EX instruction and pending branch
- br_eval  in  1  ID-stage branch requests evaluation this cycle
- br_ccc  in  3  branch condition code
- flags  out  3  registered {Z,V,N}
- br_valid  out  1  registered; one-cycle pulse, branch result ready
- br_taken  out  1  registered; branch decision, qualified by br_valid
- ovfl_cnt  out  8  saturating count of committed overflowing ADD/SUB

Function
REQ-002 SHALL commit an EX update only when ex_valid=1, stall=0, flush=0.
REQ-003 On commit, ADD and SUB SHALL set Z=(ex_out==0), N=ex_out[15], V=ex_ovfl.
REQ-004 On commit, XOR, SLL, SRA, ROR SHALL set Z=(ex_out==0) and SHALL leave V and N unchanged.
REQ-005 RED, PADDSB, memory (10xx) and control (11xx) ops SHALL leave all flags unchanged.
REQ-006 flags SHALL update on the rising edge after the commit cycle (1-cycle latency).
REQ-007 Branch evaluation SHALL use effective flags: the values REQ-003/004 would write if a commit happens this cycle, otherwise the registered flags (same-cycle bypass).
REQ-008 Conditions on effective flags: 000 NE Z=0; 001 EQ Z=1; 010 GT Z=0&N=0; 011 LT N=1; 100 GTE Z=1|N=0; 101 LTE Z=1|N=1; 110 OVFL V=1; 111 UNCOND always.
REQ-009 A branch SHALL be accepted when br_eval=1, stall=0, flush=0; br_valid SHALL be 1 and br_taken SHALL hold the decision on the next cycle only.
REQ-010 br_valid SHALL be 0 in every cycle not following an accepted branch; br_taken SHALL be 0 whenever br_valid=0.
REQ-011 Under stall=1, flags, br_valid/br_taken and ovfl_cnt SHALL not change except br_valid/br_taken, which SHALL clear to 0.
REQ-012 flush=1 SHALL suppress both the EX commit and branch acceptance that cycle; flush takes priority over stall.
REQ-013 ovfl_cnt SHALL increment by 1 on each committed ADD/SUB with ex_ovfl=1 and SHALL saturate at 8'hFF.
REQ-014 ex_ovfl SHALL be ignored for every op other than ADD/SUB.
REQ-015 Back-to-back commits SHALL each take effect; a branch evaluated in the same cycle as the second commit SHALL see the second commit's values.

Reset
REQ-016 rst=1 at a rising edge SHALL force flags=3'b000, br_valid=0, br_taken=0, ovfl_cnt=0, overriding all other inputs.
REQ-017 Reset SHALL be synchronous; outputs SHALL not change on rst alone between edges.
REQ-018 A branch accepted in the cycle rst is asserted SHALL be discarded (br_valid=0 after the edge).

Verification
REQ-019 Reset then ADD commit with ex_out=16'h0000, ex_ovfl=1 -> next cycle flags {Z,V,N}=3'b110, ovfl_cnt=1.
REQ-020 SUB commit with ex_out=16'h8001, ex_ovfl=0, then XOR commit with ex_out=0 -> flags 001 then 101 (V, N preserved by XOR).
REQ-021 Flags {Z,V,N}=000; same cycle: ADD commit ex_out=16'hFFFF and br_eval with ccc=011 (LT) -> next cycle br_valid=1, br_taken=1 (bypass).
REQ-022 br_eval ccc=111 with stall=1 -> br_valid=0; same with flush=1 -> br_valid=0; released -> br_valid=1, br_taken=1.
REQ-023 300 committed ADDs with ex_ovfl=1 -> ovfl_cnt=8'hFF, no wrap; PADDSB with ex_ovfl=1 -> count and flags unchanged.
REQ-024 rst asserted mid-sequence with flags=111 and a pending br_eval -> next cycle flags=000, br_valid=0, ovfl_cnt=0.
